// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - MIPS-style HI/LO multiply/divide controller around an unsigned md unit
//
// Purpose: accepts MULTU/MULT/DIVU/DIV requests, issues operand magnitudes to an
// external unsigned multiply/divide unit, applies sign fix-up to its result and
// updates the architectural HI/LO registers. Also handles MTHI/MTLO writes, flush
// and divide-by-zero.
//
// Ports:
//   clk, rst_n              clock; asynchronous reset, asserted when rst_n=1
//   req_valid/req_ready     request handshake; req_op selects MULTU/MULT/DIVU/DIV
//   req_a, req_b            rs / rt operands
//   flush                   discard the in-flight operation
//   wr_hi, wr_lo, wr_data   MTHI/MTLO writes (ignored while busy)
//   hi, lo                  architectural HI/LO
//   busy, done              operation in flight / one-cycle result pulse
//   md_valid, md_mode       start strobe and mode (0 multu, 1 divu) to the md unit
//   md_in_A, md_in_B        operand magnitudes to the md unit
//   md_ready, md_out        completion strobe and raw result from the md unit
module muldiv_ctrl #(
  parameter logic [31:0] DIV0_QUOT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        md_valid,
  output logic        md_mode,
  output logic [31:0] md_in_A,
  output logic [31:0] md_in_B,
  input  logic        md_ready,
  input  logic [63:0] md_out
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIX, DRAIN} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic        sign_a, sign_b, div0;
  logic [31:0] mag_a, mag_b;
  logic [63:0] res_q;
  logic        md_valid_q, done_q;

  // A flush arriving in ISSUE or FIX must kill the strobe in that same cycle.
  assign md_valid = md_valid_q & ~flush;
  assign done     = done_q & ~flush;

  logic        accept, req_signed, req_div0;
  logic [31:0] req_mag_a, req_mag_b;

  assign accept     = req_valid & req_ready;
  assign req_signed = req_op[0];
  assign req_mag_a  = (req_signed && req_a[31]) ? -req_a : req_a;
  assign req_mag_b  = (req_signed && req_b[31]) ? -req_b : req_b;
  assign req_div0   = req_op[1] && (req_b == 32'd0);

  logic [63:0] prod;
  logic [31:0] quot, rem, raw_a, fix_hi, fix_lo;

  always_comb begin
    prod = res_q;
    if (op_q == 2'b01 && (sign_a ^ sign_b)) prod = -res_q;
    quot = res_q[31:0];
    rem  = res_q[63:32];
    if (op_q == 2'b11) begin
      if (sign_a ^ sign_b) quot = -res_q[31:0];
      if (sign_a)          rem  = -res_q[63:32];
    end
    // Rebuild the original dividend for HI on divide-by-zero; 0x80000000 round-trips.
    raw_a = sign_a ? -mag_a : mag_a;
    if (div0)         {fix_hi, fix_lo} = {raw_a, DIV0_QUOT};
    else if (op_q[1]) {fix_hi, fix_lo} = {rem, quot};
    else              {fix_hi, fix_lo} = prod;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      hi         <= '0;
      lo         <= '0;
      busy       <= 1'b0;
      req_ready  <= 1'b0;
      done_q     <= 1'b0;
      md_valid_q <= 1'b0;
      md_mode    <= 1'b0;
      md_in_A    <= '0;
      md_in_B    <= '0;
      op_q       <= '0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      div0       <= 1'b0;
      mag_a      <= '0;
      mag_b      <= '0;
      res_q      <= '0;
    end else begin
      done_q     <= 1'b0;
      md_valid_q <= 1'b0;
      if (!busy) begin
        if (wr_hi) hi <= wr_data;
        if (wr_lo) lo <= wr_data;
      end
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            op_q      <= req_op;
            sign_a    <= req_signed & req_a[31];
            sign_b    <= req_signed & req_b[31];
            mag_a     <= req_mag_a;
            mag_b     <= req_mag_b;
            div0      <= req_div0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_div0) begin
              state  <= FIX;
              done_q <= 1'b1;
            end else begin
              state      <= ISSUE;
              md_valid_q <= 1'b1;
              md_mode    <= req_op[1];
              md_in_A    <= req_mag_a;
              md_in_B    <= req_mag_b;
            end
          end
        end
        ISSUE: begin
          md_mode <= 1'b0;
          md_in_A <= '0;
          md_in_B <= '0;
          if (flush) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (md_ready) begin
            if (flush) begin
              // Result and flush coincide: nothing left to drain.
              state     <= IDLE;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              res_q  <= md_out;
              state  <= FIX;
              done_q <= 1'b1;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        FIX: begin
          if (!flush) begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        DRAIN: begin
          if (md_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        flush = 1'b0;
  logic        wr_hi = 1'b0, wr_lo = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] hi, lo;
  logic        busy, done, md_valid, md_mode;
  logic [31:0] md_in_A, md_in_B;
  logic        md_ready;
  logic [63:0] md_out;

  muldiv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .md_valid(md_valid), .md_mode(md_mode),
    .md_in_A(md_in_A), .md_in_B(md_in_B), .md_ready(md_ready), .md_out(md_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Unsigned md unit model: md_ready 33 cycles after the md_valid cycle.
  logic [5:0] md_cnt;
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      md_cnt <= '0; md_ready <= 1'b0; md_out <= '0;
    end else begin
      md_ready <= (md_cnt == 6'd1);
      if (md_valid) begin
        md_cnt <= 6'd32;
        if (md_mode)
          md_out <= (md_in_B != 0) ? {md_in_A % md_in_B, md_in_A / md_in_B} : 64'hFFFFFFFF_FFFFFFFF;
        else
          md_out <= 64'(md_in_A) * 64'(md_in_B);
      end else if (md_cnt != 0) begin
        md_cnt <= md_cnt - 6'd1;
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mag(input logic [1:0] op, input logic [31:0] x);
    return (op[0] && x[31]) ? -x : x;
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, exp_hi, exp_lo;
  } vec_t;

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic run_op(input vec_t v);
    int a_cyc, d_cyc, mdv_cnt;
    bit d0, got;
    logic [63:0] e;
    d0 = v.op[1] && (v.b == 0);
    @(negedge clk);
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
    #1 check("req_ready_at_accept", req_ready, 1);
    a_cyc = cyc;
    sb_q.push_back({v.exp_hi, v.exp_lo});
    step();
    req_valid = 1'b0;
    check("md_valid_A1", md_valid, !d0);
    if (!d0) begin
      check("md_in_A", md_in_A, mag(v.op, v.a));
      check("md_in_B", md_in_B, mag(v.op, v.b));
      check("md_mode", md_mode, v.op[1]);
    end
    got = 0; mdv_cnt = 0; d_cyc = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (md_valid) mdv_cnt++;
      if (done) begin got = 1; d_cyc = cyc; end
      else step();
    end
    check("done_seen", got, 1);
    check("md_valid_count", mdv_cnt, d0 ? 0 : 1);
    if (got) check("done_latency", d_cyc - a_cyc, d0 ? 1 : 35);
    step();
    e = sb_q.pop_front();
    check("hi", hi, e[63:32]);
    check("lo", lo, e[31:0]);
    check("done_pulse_end", done, 0);
    check("ready_after", req_ready, 1);
  endtask

  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int a_cyc);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    #1 a_cyc = cyc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 200 && cyc < n; i++) step();
  endtask

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, seen_done, rdy_cyc;
    logic [31:0] h0, l0;

    vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
    vecs[1] = '{2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{2'b10, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF};
    vecs[4] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{2'b10, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[6] = '{2'b01, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006};
    vecs[7] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8] = '{2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[9] = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

    // Reset state
    step(); step();
    check("rst_hi", hi, 0); check("rst_lo", lo, 0); check("rst_busy", busy, 0);
    check("rst_done", done, 0); check("rst_md_valid", md_valid, 0);
    check("rst_req_ready", req_ready, 0);
    rst_n = 1'b0;
    step();
    check("ready_after_reset", req_ready, 1);

    foreach (vecs[i]) run_op(vecs[i]);

    // Flush in ISSUE: strobe suppressed, back to IDLE
    accept(2'b00, 32'd9, 32'd9, a);
    flush = 1'b1; #1;
    check("issue_flush_md_valid", md_valid, 0);
    step();
    flush = 1'b0;
    check("issue_flush_ready", req_ready, 1);
    check("issue_flush_busy", busy, 0);
    check("issue_flush_lo", lo, 32'h0);

    // Flush at A+10 during MULTU: DRAIN until md_ready, no done, HI/LO kept
    h0 = hi; l0 = lo;
    accept(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, a);
    seen_done = 0; rdy_cyc = -1;
    for (int i = 0; i < 60 && rdy_cyc < 0; i++) begin
      flush = (cyc == a + 10); #1;
      if (done) seen_done++;
      if (md_ready) rdy_cyc = cyc;
      else step();
    end
    flush = 1'b0;
    check("drain_md_ready_cycle", rdy_cyc - a, 34);
    check("drain_busy", busy, 1);
    step();
    check("drain_no_done", seen_done, 0);
    check("drain_ready_next", req_ready, 1);
    check("drain_hi", hi, h0); check("drain_lo", lo, l0);

    // Flush in FIX: no done, no write
    accept(2'b01, 32'd4, 32'd4, a);
    wait_cyc(a + 35);
    flush = 1'b1; #1;
    check("fix_flush_done", done, 0);
    step();
    flush = 1'b0;
    check("fix_flush_hi", hi, h0); check("fix_flush_lo", lo, l0);
    check("fix_flush_busy", busy, 0);

    // MTLO while busy is ignored, while idle takes effect
    accept(2'b00, 32'd2, 32'd3, a);
    wait_cyc(a + 5);
    wr_lo = 1'b1; wr_data = 32'h1234;
    step();
    wr_lo = 1'b0;
    check("busy_wr_lo", lo, l0);
    wait_cyc(a + 37);
    check("mul_2x3_lo", lo, 32'd6);
    @(negedge clk); wr_lo = 1'b1; wr_data = 32'h1234;
    step(); wr_lo = 1'b0;
    check("idle_wr_lo", lo, 32'h1234);
    check("idle_wr_lo_hi", hi, 32'd0);
    @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hABCD;
    step(); wr_hi = 1'b0; wr_lo = 1'b0;
    check("both_wr_hi", hi, 32'hABCD); check("both_wr_lo", lo, 32'hABCD);

    // Reset mid-operation at A+20
    accept(2'b00, 32'h1000, 32'h1000, a);
    wait_cyc(a + 20);
    rst_n = 1'b1; #1;
    check("midrst_hi", hi, 0); check("midrst_lo", lo, 0); check("midrst_busy", busy, 0);
    check("midrst_done", done, 0); check("midrst_md_valid", md_valid, 0);
    check("midrst_ready", req_ready, 0);
    step();
    rst_n = 1'b0;
    step();
    run_op('{2'b00, 32'd2, 32'd3, 32'd0, 32'd6});

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Parameters
REQ-001 The block SHALL have parameter DIV0_QUOT, default 32'hFFFFFFFF, giving the LO value written on divide-by-zero.

Interface
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous and active-high (asserted when 1); port name kept per codebase convention.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a pipeline request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the controller accepts a request this cycle.
REQ-006 The block SHALL have port req_op, input, 2 bits: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 The block SHALL have ports req_a and req_b, input, 32 bits each: rs and rt operands.
REQ-008 The block SHALL have port flush, input, 1 bit: discard the in-flight operation.
REQ-009 The block SHALL have ports wr_hi and wr_lo (input, 1 bit each) and wr_data (input, 32 bits) for MTHI/MTLO.
REQ-010 The block SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO.
REQ-011 The block SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle pulse when HI/LO take a new result.
REQ-013 The block SHALL have ports md_valid (output, 1 bit) and md_mode (output, 1 bit; 0 multu, 1 divu) toward the unsigned multiply/divide unit.
REQ-014 The block SHALL have ports md_in_A and md_in_B, output, 32 bits each, toward that unit.
REQ-015 The block SHALL have ports md_ready (input, 1 bit) and md_out (input, 64 bits) from that unit.

Function
REQ-016 The FSM SHALL use states IDLE, ISSUE, WAIT, FIX and DRAIN.
REQ-017 req_ready SHALL equal (state==IDLE); acceptance is req_valid & req_ready at a rising edge.
REQ-018 On acceptance, the block SHALL latch op, sign flags (signed ops only), and operand magnitudes (|x| for signed ops, raw x for unsigned ops).
REQ-019 On acceptance of DIVU/DIV with req_b==0, the block SHALL go to FIX without issuing; FIX then writes HI=req_a and LO=DIV0_QUOT.
REQ-020 All other accepted requests SHALL go IDLE->ISSUE.
REQ-021 In ISSUE the block SHALL hold md_valid=1 for exactly one cycle, driving md_mode=op[1], md_in_A and md_in_B = latched magnitudes, then go to WAIT.
REQ-022 md_valid SHALL be 0 in every state except ISSUE; md_in_A/md_in_B SHALL be 0 in IDLE.
REQ-023 In WAIT, md_ready=1 SHALL capture md_out and move to FIX; otherwise the block SHALL stay in WAIT.
REQ-024 In FIX, a multiply SHALL write {HI,LO} = product, negated (64-bit two's complement) when MULT and the operand signs differ.
REQ-025 In FIX, a divide SHALL take quotient = md_out[31:0] and remainder = md_out[63:32].
REQ-026 For DIV, the quotient SHALL be negated if signs differ and the remainder negated if the dividend is negative; LO = quotient, HI = remainder.
REQ-027 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0, with no exception.
REQ-028 In FIX, done SHALL be 1 for that one cycle, HI/LO SHALL update at the end of that cycle, and the state SHALL return to IDLE.
REQ-029 Latency: md_valid SHALL be in cycle A+1 after acceptance cycle A; md_ready arrives at A+34; done SHALL be at A+35; divide-by-zero done SHALL be at A+1.
REQ-030 busy SHALL be 1 in ISSUE, WAIT, FIX and DRAIN.
REQ-031 flush in ISSUE SHALL return to IDLE with md_valid suppressed; flush in WAIT SHALL go to DRAIN.
REQ-032 flush in FIX SHALL suppress the HI/LO write and done; flush in IDLE or DRAIN SHALL have no effect.
REQ-033 DRAIN SHALL wait for md_ready, discard md_out, and return to IDLE without done.
REQ-034 wr_hi/wr_lo SHALL update HI/LO only when not busy; while busy they SHALL be ignored.
REQ-035 When not busy and both wr_hi and wr_lo are 1, both HI and LO SHALL take wr_data.

Reset
REQ-036 While rst_n=1, the block SHALL immediately force state=IDLE, hi=lo=0, busy=0, done=0, md_valid=0, req_ready=0, and clear all latched operands.
REQ-037 A reset mid-operation SHALL abandon the operation; the same rst_n SHALL reset the multiply/divide unit.
REQ-038 req_ready SHALL return to 1 in the first cycle after reset deasserts.

Verification
REQ-039 MULTU a=0xFFFFFFFF, b=2 -> md_valid at A+1; done at A+35; HI=0x00000001, LO=0xFFFFFFFE.
REQ-040 MULT a=-3, b=5 -> md_in_A=3, md_in_B=5; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-041 DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7, b=0 -> done at A+1, HI=7, LO=0xFFFFFFFF, md_valid never 1.
REQ-042 Flush at A+10 during MULTU -> DRAIN until md_ready, no done, HI/LO unchanged, req_ready=1 the cycle after md_ready.
REQ-043 wr_lo=1, wr_data=0x1234 while busy -> LO unchanged; same write while idle -> LO=0x1234 next cycle.
REQ-044 rst_n pulsed at A+20 -> all outputs at reset values immediately; a new MULTU 2x3 then gives LO=6, HI=0.
